// File: rtl/axi4_straddle_packer.sv
// axi4_straddle_packer: packs dword-0 aligned TLPs (one per AXI4-Stream
// packet) into the 512-bit PCIe straddled format. A new TLP may begin at
// dword 8 of the beat that holds the previous TLP's tail, and the 161-bit
// straddle TUSER (is_sop/is_eop/pointers/discontinue) is generated alongside.
module axi4_straddle_packer #(
   parameter int AXI_TUSER_L     = 161,
   parameter bit ENABLE_STRADDLE = 1'b1
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic [511:0]           S_AXIS_TDATA,
   input  logic [15:0]            S_AXIS_TKEEP,
   input  logic                   S_AXIS_TLAST,
   input  logic                   S_AXIS_TDISCONTINUE,
   input  logic                   S_AXIS_TVALID,
   output logic                   S_AXIS_TREADY,
   output logic [511:0]           M_AXIS_TDATA,
   output logic [15:0]            M_AXIS_TKEEP,
   output logic [AXI_TUSER_L-1:0] M_AXIS_TUSER,
   output logic                   M_AXIS_TLAST,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic                   error_invalid_state
);

   // ALIGN: TLPs sit at dword 0. SHIFT: the current TLP started at dword 8 and
   // the carry holds its previous upper half. TAIL: the carry holds a complete
   // TLP tail waiting for a partner in dwords 8-15.
   typedef enum logic [1:0] {ALIGN, SHIFT, TAIL} state_e;

   state_e                   state_q;
   logic [255:0]             c_data_q;
   logic [7:0]               c_keep_q;
   logic                     c_sop_q;
   logic [2:0]               c_eop_ptr_q;
   logic                     c_disc_q;
   logic                     first_q;
   logic [511:0]             m_data_q;
   logic [15:0]              m_keep_q;
   logic [AXI_TUSER_L-1:0]   m_user_q;
   logic                     m_last_q;
   logic                     m_valid_q;
   logic                     err_q;

   logic                     out_rdy;
   logic                     accept;
   logic                     in_upper_empty;
   logic                     keep_bad;
   logic [3:0]               in_last_idx;

   // Builds a straddle TUSER word with every unused bit held at zero.
   function automatic logic [AXI_TUSER_L-1:0] mk_user(
      input logic [1:0] is_sop,
      input logic [1:0] sop0_ptr,
      input logic [1:0] sop1_ptr,
      input logic [1:0] is_eop,
      input logic [3:0] eop0_ptr,
      input logic [3:0] eop1_ptr,
      input logic       disc
   );
      logic [AXI_TUSER_L-1:0] u;
      u        = '0;
      u[65:64] = is_sop;
      u[69:68] = sop0_ptr;
      u[71:70] = sop1_ptr;
      u[77:76] = is_eop;
      u[83:80] = eop0_ptr;
      u[87:84] = eop1_ptr;
      u[96]    = disc;
      return u;
   endfunction

   assign out_rdy        = !m_valid_q || M_AXIS_TREADY;
   assign accept         = S_AXIS_TVALID && out_rdy;
   assign in_upper_empty = (S_AXIS_TKEEP[15:8] == 8'h00);
   // Keep must be non-zero and contiguous from bit 0 (k & (k+1) == 0).
   assign keep_bad       = (S_AXIS_TKEEP == 16'h0000) ||
                           ((S_AXIS_TKEEP & 16'(S_AXIS_TKEEP + 16'd1)) != 16'h0000);

   // Highest kept dword of the incoming beat; this is the TLP's last dword.
   always_comb begin
      in_last_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (S_AXIS_TKEEP[i]) in_last_idx = 4'(i);
      end
   end

   // Packing FSM with registered output stage, carry register and error pulse.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= ALIGN;
         c_data_q    <= '0;
         c_keep_q    <= '0;
         c_sop_q     <= 1'b0;
         c_eop_ptr_q <= '0;
         c_disc_q    <= 1'b0;
         first_q     <= 1'b1;
         m_data_q    <= '0;
         m_keep_q    <= '0;
         m_user_q    <= '0;
         m_last_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below reads
         // the pre-edge value of each register regardless of statement order.
         err_q <= accept && (keep_bad || (state_q == TAIL && !first_q));
         if (accept) first_q <= S_AXIS_TLAST;

         // NOTE: with !out_rdy nothing is assigned, so the whole output beat and
         // the carry hold their values for as long as the sink stalls.
         if (out_rdy) begin
            m_valid_q <= 1'b0;
            unique case (state_q)
               ALIGN: begin
                  if (S_AXIS_TVALID) begin
                     if (ENABLE_STRADDLE && S_AXIS_TLAST && in_upper_empty) begin
                        c_data_q    <= S_AXIS_TDATA[255:0];
                        c_keep_q    <= S_AXIS_TKEEP[7:0];
                        c_sop_q     <= first_q;
                        c_eop_ptr_q <= in_last_idx[2:0];
                        c_disc_q    <= S_AXIS_TDISCONTINUE;
                        state_q     <= TAIL;
                     end else begin
                        m_data_q  <= S_AXIS_TDATA;
                        m_keep_q  <= S_AXIS_TKEEP;
                        m_user_q  <= mk_user({1'b0, first_q}, 2'b00, 2'b00,
                                             {1'b0, S_AXIS_TLAST}, in_last_idx, 4'd0,
                                             S_AXIS_TLAST && S_AXIS_TDISCONTINUE);
                        m_last_q  <= S_AXIS_TLAST;
                        m_valid_q <= 1'b1;
                     end
                  end
               end
               SHIFT: begin
                  if (S_AXIS_TVALID) begin
                     m_data_q  <= {S_AXIS_TDATA[255:0], c_data_q};
                     m_keep_q  <= {S_AXIS_TKEEP[7:0], c_keep_q};
                     m_valid_q <= 1'b1;
                     c_data_q  <= S_AXIS_TDATA[511:256];
                     c_keep_q  <= S_AXIS_TKEEP[15:8];
                     if (S_AXIS_TLAST && in_upper_empty) begin
                        m_user_q <= mk_user(2'b00, 2'b00, 2'b00, 2'b01,
                                            {1'b1, in_last_idx[2:0]}, 4'd0,
                                            S_AXIS_TDISCONTINUE);
                        m_last_q <= 1'b1;
                        state_q  <= ALIGN;
                     end else begin
                        m_user_q <= '0;
                        m_last_q <= 1'b0;
                        if (S_AXIS_TLAST) begin
                           c_sop_q     <= 1'b0;
                           c_eop_ptr_q <= in_last_idx[2:0];
                           c_disc_q    <= S_AXIS_TDISCONTINUE;
                           state_q     <= TAIL;
                        end
                     end
                  end
               end
               TAIL: begin
                  m_valid_q <= 1'b1;
                  m_last_q  <= 1'b1;
                  if (S_AXIS_TVALID) begin
                     // Carry tail in dwords 0-7, new TLP starting at dword 8.
                     m_data_q <= {S_AXIS_TDATA[255:0], c_data_q};
                     m_keep_q <= {S_AXIS_TKEEP[7:0], c_keep_q};
                     if (S_AXIS_TLAST && in_upper_empty) begin
                        m_user_q <= mk_user(c_sop_q ? 2'b11 : 2'b01,
                                            c_sop_q ? 2'b00 : 2'b10, c_sop_q ? 2'b10 : 2'b00,
                                            2'b11, {1'b0, c_eop_ptr_q},
                                            {1'b1, in_last_idx[2:0]},
                                            c_disc_q || S_AXIS_TDISCONTINUE);
                        state_q  <= ALIGN;
                     end else begin
                        m_user_q <= mk_user(c_sop_q ? 2'b11 : 2'b01,
                                            c_sop_q ? 2'b00 : 2'b10, c_sop_q ? 2'b10 : 2'b00,
                                            2'b01, {1'b0, c_eop_ptr_q}, 4'd0, c_disc_q);
                        c_data_q <= S_AXIS_TDATA[511:256];
                        c_keep_q <= S_AXIS_TKEEP[15:8];
                        c_sop_q  <= 1'b0;
                        if (S_AXIS_TLAST) begin
                           c_eop_ptr_q <= in_last_idx[2:0];
                           c_disc_q    <= S_AXIS_TDISCONTINUE;
                           state_q     <= TAIL;
                        end else begin
                           state_q     <= SHIFT;
                        end
                     end
                  end else begin
                     // No partner available: flush the tail on its own.
                     m_data_q <= {256'd0, c_data_q};
                     m_keep_q <= {8'h00, c_keep_q};
                     m_user_q <= mk_user({1'b0, c_sop_q}, 2'b00, 2'b00, 2'b01,
                                         {1'b0, c_eop_ptr_q}, 4'd0, c_disc_q);
                     state_q  <= ALIGN;
                  end
               end
               default: state_q <= ALIGN;
            endcase
         end
      end
   end

   assign S_AXIS_TREADY       = out_rdy;
   assign M_AXIS_TDATA        = m_data_q;
   assign M_AXIS_TKEEP        = m_keep_q;
   assign M_AXIS_TUSER        = m_user_q;
   assign M_AXIS_TLAST        = m_last_q;
   assign M_AXIS_TVALID       = m_valid_q;
   assign error_invalid_state = err_q;

endmodule

// File: tb/tb_axi4_straddle_packer.sv
// Testbench for axi4_straddle_packer: directed straddle scenarios with exact
// expected beats, plus a randomized run whose output is de-straddled by a
// TUSER-driven reference parser and compared TLP by TLP with the input.
module tb_axi4_straddle_packer;

   logic         ACLK = 1'b0;
   logic         ARESET;
   logic [511:0] S_AXIS_TDATA;
   logic [15:0]  S_AXIS_TKEEP;
   logic         S_AXIS_TLAST;
   logic         S_AXIS_TDISCONTINUE;
   logic         S_AXIS_TVALID;
   logic         S_AXIS_TREADY;
   logic [511:0] M_AXIS_TDATA;
   logic [15:0]  M_AXIS_TKEEP;
   logic [160:0] M_AXIS_TUSER;
   logic         M_AXIS_TLAST;
   logic         M_AXIS_TVALID;
   logic         M_AXIS_TREADY;
   logic         error_invalid_state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [511:0] data;
      logic [15:0]  keep;
      logic         last;
      logic         disc;
   } beat_t;

   always #5 ACLK = ~ACLK;

   axi4_straddle_packer #(.AXI_TUSER_L(161), .ENABLE_STRADDLE(1'b1)) dut (
      .ACLK                (ACLK),
      .ARESET              (ARESET),
      .S_AXIS_TDATA        (S_AXIS_TDATA),
      .S_AXIS_TKEEP        (S_AXIS_TKEEP),
      .S_AXIS_TLAST        (S_AXIS_TLAST),
      .S_AXIS_TDISCONTINUE (S_AXIS_TDISCONTINUE),
      .S_AXIS_TVALID       (S_AXIS_TVALID),
      .S_AXIS_TREADY       (S_AXIS_TREADY),
      .M_AXIS_TDATA        (M_AXIS_TDATA),
      .M_AXIS_TKEEP        (M_AXIS_TKEEP),
      .M_AXIS_TUSER        (M_AXIS_TUSER),
      .M_AXIS_TLAST        (M_AXIS_TLAST),
      .M_AXIS_TVALID       (M_AXIS_TVALID),
      .M_AXIS_TREADY       (M_AXIS_TREADY),
      .error_invalid_state (error_invalid_state)
   );

   logic [178:0] ctl_obs;
   assign ctl_obs = {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TUSER};

   // Expected TUSER from the straddle field layout.
   function automatic logic [160:0] mk_user(input logic [1:0] sop, input logic [1:0] s0,
                                            input logic [1:0] s1, input logic [1:0] eop,
                                            input logic [3:0] e0, input logic [3:0] e1,
                                            input logic disc);
      logic [160:0] u;
      u = '0;
      u[65:64] = sop; u[69:68] = s0; u[71:70] = s1;
      u[77:76] = eop; u[83:80] = e0; u[87:84] = e1;
      u[96] = disc;
      return u;
   endfunction

   function automatic logic [178:0] mk_ctl(input logic v, input logic l,
                                           input logic [15:0] k, input logic [160:0] u);
      return {v, l, k, u};
   endfunction

   // Random payload with dwords outside the keep mask forced to zero.
   function automatic logic [511:0] rnd_data(input logic [15:0] k);
      logic [511:0] d;
      d = '0;
      for (int i = 0; i < 16; i++) begin
         if (k[i]) d[i*32 +: 32] = $urandom;
      end
      return d;
   endfunction

   // Present one beat at the falling edge; it is taken at the next rising edge.
   task automatic put(input logic [511:0] d, input logic [15:0] k, input logic l,
                      input logic dc);
      int n;
      @(negedge ACLK);
      S_AXIS_TDATA = d; S_AXIS_TKEEP = k; S_AXIS_TLAST = l;
      S_AXIS_TDISCONTINUE = dc; S_AXIS_TVALID = 1'b1;
      #1;
      n = 0;
      while (!S_AXIS_TREADY && n < 100) begin
         @(negedge ACLK); #1; n++;
      end
      n_checks++;
      if (S_AXIS_TREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL put_ready_timeout: S_AXIS_TREADY got %b want 1", S_AXIS_TREADY);
      end
   endtask

   task automatic idle();
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TDISCONTINUE = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      ARESET = 1'b1; M_AXIS_TREADY = 1'b1;
      S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0;
      S_AXIS_TLAST = 1'b0; S_AXIS_TDISCONTINUE = 1'b0;
      repeat (3) @(negedge ACLK);
      #1;
      n_checks++;
      if (ctl_obs !== 179'd0) begin
         n_fail++; $display("FAIL reset_ctl: got %h want 0", ctl_obs);
      end
      n_checks++;
      if (M_AXIS_TDATA !== 512'd0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", M_AXIS_TDATA);
      end
      n_checks++;
      if (error_invalid_state !== 1'b0) begin
         n_fail++; $display("FAIL reset_err: got %b want 0", error_invalid_state);
      end
      n_checks++;
      if (S_AXIS_TREADY !== 1'b1) begin
         n_fail++; $display("FAIL reset_tready: got %b want 1", S_AXIS_TREADY);
      end
      ARESET = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [511:0] a, b;
      logic [178:0] exp_c;
      a = rnd_data(16'hFFFF); b = rnd_data(16'hFFFF);
      exp_c = mk_ctl(1'b1, 1'b1, 16'hFFFF, mk_user(2'b01, 2'b00, 2'b00, 2'b01, 4'd15, 4'd0, 1'b0));
      put(a, 16'hFFFF, 1'b1, 1'b0);
      put(b, 16'hFFFF, 1'b1, 1'b0);
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL b2b_first_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== a) begin
         n_fail++; $display("FAIL b2b_first_data: got %h want %h", M_AXIS_TDATA, a);
      end
      idle();
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL b2b_second_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== b) begin
         n_fail++; $display("FAIL b2b_second_data: got %h want %h", M_AXIS_TDATA, b);
      end
      idle();
      n_checks++;
      if (M_AXIS_TVALID !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drained: TVALID got %b want 0", M_AXIS_TVALID);
      end
   endtask

   task automatic test_straddle_pair();
      logic [511:0] a, b, exp_d;
      logic [178:0] exp_c;
      a = rnd_data(16'h000F); b = rnd_data(16'h00FF);
      exp_d = {b[255:0], a[255:0]};
      exp_c = mk_ctl(1'b1, 1'b1, 16'hFF0F, mk_user(2'b11, 2'b00, 2'b10, 2'b11, 4'd3, 4'd15, 1'b0));
      put(a, 16'h000F, 1'b1, 1'b0);
      put(b, 16'h00FF, 1'b1, 1'b0);
      n_checks++;
      if (M_AXIS_TVALID !== 1'b0) begin
         n_fail++; $display("FAIL pair_held: TVALID got %b want 0", M_AXIS_TVALID);
      end
      idle();
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL pair_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== exp_d) begin
         n_fail++; $display("FAIL pair_data: got %h want %h", M_AXIS_TDATA, exp_d);
      end
      idle();
      n_checks++;
      if (M_AXIS_TVALID !== 1'b0) begin
         n_fail++; $display("FAIL pair_drained: TVALID got %b want 0", M_AXIS_TVALID);
      end
   endtask

   task automatic test_tail_flush();
      logic [511:0] a, exp_d;
      logic [178:0] exp_c;
      a = rnd_data(16'h000F);
      exp_d = {256'd0, a[255:0]};
      exp_c = mk_ctl(1'b1, 1'b1, 16'h000F, mk_user(2'b01, 2'b00, 2'b00, 2'b01, 4'd3, 4'd0, 1'b1));
      put(a, 16'h000F, 1'b1, 1'b1);
      idle();
      n_checks++;
      if (M_AXIS_TVALID !== 1'b0) begin
         n_fail++; $display("FAIL flush_early: TVALID got %b want 0", M_AXIS_TVALID);
      end
      idle();
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL flush_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== exp_d) begin
         n_fail++; $display("FAIL flush_data: got %h want %h", M_AXIS_TDATA, exp_d);
      end
      idle();
   endtask

   task automatic test_shift_chain();
      logic [511:0] a, b0, b1, b2, exp_d;
      logic [178:0] exp_c;
      a  = rnd_data(16'h000F); b0 = rnd_data(16'hFFFF);
      b1 = rnd_data(16'hFFFF); b2 = rnd_data(16'h000F);
      put(a,  16'h000F, 1'b1, 1'b0);
      put(b0, 16'hFFFF, 1'b0, 1'b0);
      n_checks++;
      if (M_AXIS_TVALID !== 1'b0) begin
         n_fail++; $display("FAIL shift_held: TVALID got %b want 0", M_AXIS_TVALID);
      end
      put(b1, 16'hFFFF, 1'b0, 1'b0);
      exp_c = mk_ctl(1'b1, 1'b1, 16'hFF0F, mk_user(2'b11, 2'b00, 2'b10, 2'b01, 4'd3, 4'd0, 1'b0));
      exp_d = {b0[255:0], a[255:0]};
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL shift_beat1_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== exp_d) begin
         n_fail++; $display("FAIL shift_beat1_data: got %h want %h", M_AXIS_TDATA, exp_d);
      end
      put(b2, 16'h000F, 1'b1, 1'b0);
      exp_c = mk_ctl(1'b1, 1'b0, 16'hFFFF, 161'd0);
      exp_d = {b1[255:0], b0[511:256]};
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL shift_beat2_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== exp_d) begin
         n_fail++; $display("FAIL shift_beat2_data: got %h want %h", M_AXIS_TDATA, exp_d);
      end
      idle();
      exp_c = mk_ctl(1'b1, 1'b1, 16'h0FFF, mk_user(2'b00, 2'b00, 2'b00, 2'b01, 4'd11, 4'd0, 1'b0));
      exp_d = {b2[255:0], b1[511:256]};
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL shift_beat3_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== exp_d) begin
         n_fail++; $display("FAIL shift_beat3_data: got %h want %h", M_AXIS_TDATA, exp_d);
      end
      idle();
   endtask

   task automatic test_reset_mid_packet();
      logic [511:0] a, b0, c, e;
      logic [178:0] exp_c;
      a = rnd_data(16'h000F); b0 = rnd_data(16'hFFFF); c = rnd_data(16'hFFFF);
      e = rnd_data(16'h00F3);
      put(a,  16'h000F, 1'b1, 1'b0);
      put(b0, 16'hFFFF, 1'b0, 1'b0);
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0; ARESET = 1'b1;
      @(negedge ACLK);
      #1;
      n_checks++;
      if (M_AXIS_TVALID !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_tvalid: got %b want 0", M_AXIS_TVALID);
      end
      ARESET = 1'b0;
      put(c, 16'hFFFF, 1'b1, 1'b0);
      idle();
      exp_c = mk_ctl(1'b1, 1'b1, 16'hFFFF, mk_user(2'b01, 2'b00, 2'b00, 2'b01, 4'd15, 4'd0, 1'b0));
      n_checks++;
      if (ctl_obs !== exp_c) begin
         n_fail++; $display("FAIL rst_mid_next_ctl: got %h want %h", ctl_obs, exp_c);
      end
      n_checks++;
      if (M_AXIS_TDATA !== c) begin
         n_fail++; $display("FAIL rst_mid_next_data: got %h want %h", M_AXIS_TDATA, c);
      end
      n_checks++;
      if (error_invalid_state !== 1'b0) begin
         n_fail++; $display("FAIL err_quiet: got %b want 0", error_invalid_state);
      end
      put(e, 16'h00F3, 1'b1, 1'b0);
      idle();
      n_checks++;
      if (error_invalid_state !== 1'b1) begin
         n_fail++; $display("FAIL err_pulse: got %b want 1", error_invalid_state);
      end
      idle();
      n_checks++;
      if (error_invalid_state !== 1'b0) begin
         n_fail++; $display("FAIL err_one_cycle: got %b want 0", error_invalid_state);
      end
      repeat (2) idle();
   endtask

   task automatic test_random_backpressure();
      beat_t        beats[$];
      beat_t        bt;
      int           exp_len[$];
      int           exp_off[$];
      logic         exp_disc[$];
      logic [31:0]  exp_dw[$];
      logic [31:0]  cur[$];
      logic [31:0]  w;
      int           len, cnt, bi, got;
      logic         dc, s_acc, stall_prev, in_pkt, ok, beat_disc;
      logic [178:0] sv_ctl;
      logic [511:0] sv_data;
      logic [15:0]  sop_at, eop_at;

      for (int t = 0; t < 200; t++) begin
         len = $urandom_range(1, 40);
         dc  = ($urandom_range(0, 7) == 0);
         exp_len.push_back(len); exp_disc.push_back(dc); exp_off.push_back(exp_dw.size());
         for (int b = 0; b * 16 < len; b++) begin
            cnt     = (len - b * 16 > 16) ? 16 : len - b * 16;
            bt.keep = 16'hFFFF >> (16 - cnt);
            bt.data = '0;
            for (int i = 0; i < cnt; i++) begin
               w = $urandom;
               bt.data[i*32 +: 32] = w;
               exp_dw.push_back(w);
            end
            bt.last = ((b + 1) * 16 >= len);
            bt.disc = bt.last && dc;
            beats.push_back(bt);
         end
      end

      bi = 0; got = 0; s_acc = 1'b0; stall_prev = 1'b0; in_pkt = 1'b0;
      sv_ctl = '0; sv_data = '0;
      for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
         @(negedge ACLK);
         M_AXIS_TREADY = ($urandom_range(0, 1) == 1);
         if (!S_AXIS_TVALID || s_acc) begin
            if (bi < beats.size() && $urandom_range(0, 3) != 0) begin
               S_AXIS_TDATA = beats[bi].data; S_AXIS_TKEEP = beats[bi].keep;
               S_AXIS_TLAST = beats[bi].last; S_AXIS_TDISCONTINUE = beats[bi].disc;
               S_AXIS_TVALID = 1'b1;
            end else begin
               S_AXIS_TVALID = 1'b0;
            end
         end
         #1;
         if (stall_prev) begin
            n_checks++;
            if ({ctl_obs, M_AXIS_TDATA} !== {sv_ctl, sv_data}) begin
               n_fail++;
               $display("FAIL stall_hold: ctl got %h want %h data got %h want %h",
                        ctl_obs, sv_ctl, M_AXIS_TDATA, sv_data);
            end
         end
         s_acc = S_AXIS_TVALID && S_AXIS_TREADY;
         if (s_acc) bi++;
         stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
         sv_ctl = ctl_obs; sv_data = M_AXIS_TDATA;

         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            // De-straddle this beat using only its TUSER and TKEEP.
            sop_at = '0; eop_at = '0; beat_disc = 1'b0;
            if (M_AXIS_TUSER[64]) sop_at[M_AXIS_TUSER[69] ? 8 : 0] = 1'b1;
            if (M_AXIS_TUSER[65]) sop_at[M_AXIS_TUSER[71] ? 8 : 0] = 1'b1;
            if (M_AXIS_TUSER[76]) eop_at[M_AXIS_TUSER[83:80]] = 1'b1;
            if (M_AXIS_TUSER[77]) eop_at[M_AXIS_TUSER[87:84]] = 1'b1;
            for (int d = 0; d < 16; d++) begin
               if (sop_at[d]) begin
                  n_checks++;
                  if (in_pkt !== 1'b0) begin
                     n_fail++; $display("FAIL rnd_sop_in_pkt: dword %0d in_pkt got %b want 0", d, in_pkt);
                  end
                  in_pkt = 1'b1;
                  cur.delete();
               end
               if (M_AXIS_TKEEP[d]) begin
                  if (in_pkt) cur.push_back(M_AXIS_TDATA[d*32 +: 32]);
                  else begin
                     n_checks++; n_fail++;
                     $display("FAIL rnd_keep_outside: dword %0d kept got 1 want 0", d);
                  end
               end
               if (eop_at[d]) begin
                  n_checks++;
                  if (!in_pkt || got >= 200) begin
                     n_fail++; $display("FAIL rnd_eop_orphan: dword %0d tlp %0d", d, got);
                  end else begin
                     ok = (cur.size() == exp_len[got]);
                     for (int i = 0; ok && i < cur.size(); i++) begin
                        if (cur[i] !== exp_dw[exp_off[got] + i]) ok = 1'b0;
                     end
                     if (ok !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rnd_tlp_content: tlp %0d got %0d dwords want %0d (or data differs)",
                                 got, cur.size(), exp_len[got]);
                     end
                     beat_disc = beat_disc || exp_disc[got];
                     got++;
                  end
                  in_pkt = 1'b0;
               end
            end
            n_checks++;
            if (M_AXIS_TUSER[96] !== beat_disc) begin
               n_fail++; $display("FAIL rnd_discontinue: got %b want %b", M_AXIS_TUSER[96], beat_disc);
            end
            n_checks++;
            if (M_AXIS_TLAST !== (|M_AXIS_TUSER[77:76])) begin
               n_fail++; $display("FAIL rnd_tlast: got %b want %b", M_AXIS_TLAST, |M_AXIS_TUSER[77:76]);
            end
         end
      end
      n_checks++;
      if (got !== 200) begin
         n_fail++; $display("FAIL rnd_tlp_count: got %0d want 200", got);
      end
      S_AXIS_TVALID = 1'b0; M_AXIS_TREADY = 1'b1;
      repeat (2) idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_straddle_pair();
      test_tail_flush();
      test_shift_chain();
      test_reset_mid_packet();
      test_random_backpressure();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
